mmio_pwm_led_ctrl: RTL and testbench
====================================

Name: mmio_pwm_led_ctrl

Overview:
Memory-mapped LED/GPIO output controller that replaces the raw `led = mem_map_io[7:0]` hookup in the board top. It decodes a simple single-cycle register bus from the processor and drives NUM_CH outputs. Each output can be a static bit or a per-channel PWM brightness, generated by a shared prescaler and PWM counter. It sits between the processor's memory-mapped IO port and the board pins.

Parameters:
NUM_CH, 8, number of output channels (1..32)
BUS_WIDTH, 32, data bus width
ADDR_W, 4, word-address width; 4+NUM_CH must be <= 2**ADDR_W
DUTY_W, 8, PWM duty and PWM counter width
PRE_W, 16, prescaler width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
addr  in  ADDR_W  word address
wdata  in  BUS_WIDTH  write data
we  in  1  write strobe, one cycle per access
re  in  1  read strobe, one cycle per access
rdata  out  BUS_WIDTH  registered read data
rvalid  out  1  read data valid pulse
err  out  1  access-to-unmapped-address pulse
led  out  NUM_CH  channel outputs

Behaviour:
- Reset (async assert, sync release on clk): CTRL=0, OUT=0, PRESCALE=0, all DUTY=0, counters=0, rdata=0, rvalid=0, err=0, led=0.
- Register map (word addresses):
  - 0x0 CTRL: bit0 EN, bit1 PWM_MODE; other bits read 0.
  - 0x1 OUT: bits[NUM_CH-1:0].
  - 0x2 PRESCALE: bits[PRE_W-1:0].
  - 0x3 STATUS (RO): bits[DUTY_W-1:0] = current PWM count.
  - 0x4+i DUTY[i]: bits[DUTY_W-1:0], for i < NUM_CH.
- Unused bits: writes ignore bits above the field width; reads zero-extend.
- Write: takes effect at the clk edge where we=1; the new value is visible to reads and outputs from the next cycle.
- Read: re=1 in cycle N gives rdata and rvalid=1 in cycle N+1. rvalid is 0 in all other cycles. rdata holds its last value when rvalid=0.
- we and re in the same cycle to the same address: the read returns the pre-write value.
- Unmapped address (0x4+NUM_CH and up):
  - Write is ignored; err=1 in cycle N+1.
  - Read returns 0 with rvalid=1 and err=1 in cycle N+1.
  - Writes to 0x3 are ignored with no err.
- Prescaler: runs only while EN=1.
  - pre_cnt counts 0..PRESCALE. At PRESCALE it wraps to 0 and emits a tick in that same cycle.
  - PRESCALE=0 gives a tick every cycle.
  - A write to PRESCALE resets pre_cnt to 0.
- PWM counter: increments on each tick and wraps from 2**DUTY_W-1 to 0. It is held at its value while EN=0.
- Channel i output, registered, 1-cycle latency from the state shown:
  - EN=0: 0.
  - EN=1, PWM_MODE=0: OUT[i].
  - EN=1, PWM_MODE=1: OUT[i] & (pwm_cnt < DUTY[i]).
  - DUTY=0 is always off. DUTY=2**DUTY_W-1 is on for (2**DUTY_W-1)/2**DUTY_W of the period.
- DUTY writes apply immediately; no period-boundary double-buffering.
- Reset asserted mid-access: the pending rvalid/err are dropped and all state is cleared.

Optional Feature:
Macro: MMIO_PWM_LED_BLINK_EN.
- Defined:
  - Adds register 0x3 BLINK at write address 0x3: NUM_CH bit mask. STATUS moves to read-only at 0x3 bits[DUTY_W+NUM_CH-1:NUM_CH] with BLINK in the low bits. NUM_CH+DUTY_W must be <= BUS_WIDTH.
  - A blink phase bit toggles on every PWM counter wrap.
  - A channel whose BLINK bit is set is forced to 0 while the phase bit is 1.
  - BLINK and the phase bit both reset to 0.
- Not defined: no blink logic. 0x3 behaves as STATUS as described above.

Test Plan:
- Reset while led=0xFF, then release: led=0x00, rdata=0, rvalid=0; a read of 0x1 returns 0 with rvalid one cycle after re.
- Write CTRL=0x1, OUT=0xA5: led=0xA5 one cycle after the OUT write; write CTRL=0, then led=0x00 the next cycle.
- CTRL=0x3, OUT=0xFF, PRESCALE=0, DUTY[0]=64, DUTY[1]=0, DUTY[2]=255: over 256 cycles led[0] is high 64 cycles, led[1] 0 cycles, led[2] 255 cycles.
- PRESCALE=3: STATUS increments exactly every 4 cycles; writing PRESCALE mid-count restarts the 4-cycle spacing from the write.
- Same-cycle we+re to 0x1, holding 0x0F, writing 0xF0: rdata=0x0F; the next read returns 0xF0.
- Read of address 0xC with NUM_CH=8: rdata=0, rvalid=1, err=1 in the same cycle; write to 0xC leaves all registers unchanged and gives err=1.

Source files
------------

// File: rtl/mmio_pwm_led_ctrl.sv
// Memory-mapped LED/GPIO controller: static or PWM-dimmed outputs behind a single-cycle register bus.
// Optional blink mask and phase on address 0x3 when MMIO_PWM_LED_BLINK_EN is defined.
module mmio_pwm_led_ctrl #(
  parameter int NUM_CH    = 8,
  parameter int BUS_WIDTH = 32,
  parameter int ADDR_W    = 4,
  parameter int DUTY_W    = 8,
  parameter int PRE_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [BUS_WIDTH-1:0] wdata,
  input  logic                 we,
  input  logic                 re,
  output logic [BUS_WIDTH-1:0] rdata,
  output logic                 rvalid,
  output logic                 err,
  output logic [NUM_CH-1:0]    led
);

  localparam int MAP_END = 4 + NUM_CH;

  logic [1:0]           ctrl_q, ctrl_d;
  logic [NUM_CH-1:0]    out_q, out_d;
  logic [PRE_W-1:0]     prescale_q, prescale_d;
  logic [DUTY_W-1:0]    duty_q [NUM_CH];
  logic [DUTY_W-1:0]    duty_d [NUM_CH];
  logic [PRE_W-1:0]     pre_cnt_q, pre_cnt_d;
  logic [DUTY_W-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;
  logic                 err_q, err_d;
  logic [NUM_CH-1:0]    led_q, led_d;
`ifdef MMIO_PWM_LED_BLINK_EN
  logic [NUM_CH-1:0]    blink_q, blink_d;
  logic                 phase_q, phase_d;
`endif

  logic                 en, pwm_mode, mapped, tick, wr_pre, chan_on;
  logic [BUS_WIDTH-1:0] rd_val;

  assign en       = ctrl_q[0];
  assign pwm_mode = ctrl_q[1];
  assign mapped   = 32'(addr) < 32'(MAP_END);
  assign wr_pre   = we && (addr == ADDR_W'(2));

  always_comb begin
    ctrl_d     = ctrl_q;
    out_d      = out_q;
    prescale_d = prescale_q;
    duty_d     = duty_q;
    pre_cnt_d  = pre_cnt_q;
    pwm_cnt_d  = pwm_cnt_q;
    rdata_d    = rdata_q;
    rvalid_d   = re;
    err_d      = (we || re) && !mapped;
    led_d      = '0;
    tick       = 1'b0;
    rd_val     = '0;
    chan_on    = 1'b0;
`ifdef MMIO_PWM_LED_BLINK_EN
    blink_d    = blink_q;
    phase_d    = phase_q;
`endif

    // Read mux sees pre-write state, so a same-cycle read returns the old value.
    if (addr == ADDR_W'(0)) rd_val = BUS_WIDTH'(ctrl_q);
    if (addr == ADDR_W'(1)) rd_val = BUS_WIDTH'(out_q);
    if (addr == ADDR_W'(2)) rd_val = BUS_WIDTH'(prescale_q);
`ifdef MMIO_PWM_LED_BLINK_EN
    if (addr == ADDR_W'(3)) rd_val = BUS_WIDTH'({pwm_cnt_q, blink_q});
`else
    if (addr == ADDR_W'(3)) rd_val = BUS_WIDTH'(pwm_cnt_q);
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr == ADDR_W'(4 + i)) rd_val = BUS_WIDTH'(duty_q[i]);
    end
    if (re) rdata_d = rd_val;

    if (we) begin
      if (addr == ADDR_W'(0)) ctrl_d     = wdata[1:0];
      if (addr == ADDR_W'(1)) out_d      = wdata[NUM_CH-1:0];
      if (addr == ADDR_W'(2)) prescale_d = wdata[PRE_W-1:0];
`ifdef MMIO_PWM_LED_BLINK_EN
      if (addr == ADDR_W'(3)) blink_d    = wdata[NUM_CH-1:0];
`endif
      for (int i = 0; i < NUM_CH; i++) begin
        if (addr == ADDR_W'(4 + i)) duty_d[i] = wdata[DUTY_W-1:0];
      end
    end

    // A PRESCALE write restarts the tick spacing from the write itself.
    if (wr_pre) begin
      pre_cnt_d = '0;
    end else if (en) begin
      if (pre_cnt_q == prescale_q) begin
        pre_cnt_d = '0;
        tick      = 1'b1;
      end else begin
        pre_cnt_d = pre_cnt_q + 1'b1;
      end
    end
    if (tick) pwm_cnt_d = pwm_cnt_q + 1'b1;
`ifdef MMIO_PWM_LED_BLINK_EN
    if (tick && (pwm_cnt_q == '1)) phase_d = ~phase_q;
`endif

    for (int i = 0; i < NUM_CH; i++) begin
      chan_on = out_q[i] && (!pwm_mode || (pwm_cnt_q < duty_q[i]));
`ifdef MMIO_PWM_LED_BLINK_EN
      chan_on = chan_on && !(blink_q[i] && phase_q);
`endif
      led_d[i] = en && chan_on;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      out_q      <= '0;
      prescale_q <= '0;
      duty_q     <= '{default: '0};
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      led_q      <= '0;
`ifdef MMIO_PWM_LED_BLINK_EN
      blink_q    <= '0;
      phase_q    <= 1'b0;
`endif
    end else begin
      ctrl_q     <= ctrl_d;
      out_q      <= out_d;
      prescale_q <= prescale_d;
      duty_q     <= duty_d;
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      led_q      <= led_d;
`ifdef MMIO_PWM_LED_BLINK_EN
      blink_q    <= blink_d;
      phase_q    <= phase_d;
`endif
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign led    = led_q;

endmodule

// File: tb/tb_mmio_pwm_led_ctrl.sv
// Scoreboard bench for mmio_pwm_led_ctrl (default build, NUM_CH=8).
module tb_mmio_pwm_led_ctrl;

  localparam int NCH = 8;

  logic        clk;
  logic        rst_n;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
  logic [7:0]  led;

  mmio_pwm_led_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr   (addr),
    .wdata  (wdata),
    .we     (we),
    .re     (re),
    .rdata  (rdata),
    .rvalid (rvalid),
    .err    (err),
    .led    (led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          due;
    logic        rv;
    logic        er;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ncyc  = 0;

  logic [1:0]  m_ctrl;
  logic [7:0]  m_out;
  logic [15:0] m_pre;
  logic [7:0]  m_duty [NCH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [3:0] a);
    if (a == 4'd0) return {30'd0, m_ctrl};
    if (a == 4'd1) return {24'd0, m_out};
    if (a == 4'd2) return {16'd0, m_pre};
    if (a >= 4'd4 && 32'(a) < 4 + NCH) return {24'd0, m_duty[a - 4'd4]};
    return 32'd0;
  endfunction

  task automatic model_reset();
    m_ctrl = '0;
    m_out  = '0;
    m_pre  = '0;
    for (int i = 0; i < NCH; i++) m_duty[i] = '0;
  endtask

  // Response appears at the second negedge after the drive point.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (sb.size() > 0 && sb[0].due == ncyc) begin
      e = sb.pop_front();
      chk("rvalid", {31'd0, rvalid}, {31'd0, e.rv});
      chk("err", {31'd0, err}, {31'd0, e.er});
      if (e.rv) chk("rdata", rdata, e.d);
    end else if (rvalid || err) begin
      chk("spurious_rsp", {30'd0, rvalid, err}, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    we = 1'b0;
    re = 1'b0;
  endtask

  task automatic acc(input logic w, input logic r, input logic [3:0] a,
                     input logic [31:0] d, input logic [31:0] rexp);
    exp_t e;
    logic bad;
    @(posedge clk);
    #1;
    we = w; re = r; addr = a; wdata = d;
    bad = 32'(a) >= 4 + NCH;
    if (r || (w && bad)) begin
      e.due = ncyc + 2;
      e.rv  = r;
      e.er  = bad;
      e.d   = rexp;
      sb.push_back(e);
    end
    if (w && !bad) begin
      if (a == 4'd0) m_ctrl = d[1:0];
      if (a == 4'd1) m_out  = d[7:0];
      if (a == 4'd2) m_pre  = d[15:0];
      if (a >= 4'd4) m_duty[a - 4'd4] = d[7:0];
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    acc(1'b1, 1'b0, a, d, 32'd0);
  endtask

  task automatic rd(input logic [3:0] a);
    acc(1'b0, 1'b1, a, 32'd0, model_rd(a));
  endtask

  task automatic rd_st(input logic [31:0] exp);
    acc(1'b0, 1'b1, 4'd3, 32'd0, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt [4];
    rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    model_reset();
    repeat (3) step();
    chk("rst_led", {24'd0, led}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;

    // Drive led to all-ones, then reset with a read in flight.
    wr(4'd0, 32'h1);
    wr(4'd1, 32'hFF);
    step();
    step();
    chk("led_ff", {24'd0, led}, 32'hFF);
    @(posedge clk);
    #1;
    addr = 4'd1; re = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_led", {24'd0, led}, 32'd0);
    chk("midrst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    re = 1'b0;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    rd(4'd1);
    rd(4'd0);
    rd(4'd2);
    rd(4'd9);

    // Prescaler spacing, then a restart from a mid-count PRESCALE write.
    wr(4'd2, 32'd3);
    wr(4'd0, 32'h1);
    for (int j = 0; j < 18; j++) rd_st(32'(j / 4));
    wr(4'd2, 32'd3);
    for (int k = 0; k < 12; k++) rd_st(32'(4 + k / 4));
    wr(4'd0, 32'h0);

    // Static mode.
    wr(4'd0, 32'h1);
    wr(4'd1, 32'hA5);
    step();
    chk("led_pre_out", {24'd0, led}, 32'h00);
    step();
    chk("led_a5", {24'd0, led}, 32'hA5);
    wr(4'd0, 32'h0);
    step();
    chk("led_en_lag", {24'd0, led}, 32'hA5);
    step();
    chk("led_off", {24'd0, led}, 32'h00);

    // PWM duty over one full period.
    wr(4'd2, 32'd0);
    wr(4'd4, 32'd64);
    wr(4'd5, 32'd0);
    wr(4'd6, 32'd255);
    wr(4'd1, 32'hFF);
    wr(4'd0, 32'h3);
    repeat (3) step();
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int n = 0; n < 256; n++) begin
      step();
      for (int c = 0; c < 4; c++) cnt[c] += int'(led[c]);
    end
    chk("pwm_duty64", 32'(cnt[0]), 32'd64);
    chk("pwm_duty0", 32'(cnt[1]), 32'd0);
    chk("pwm_duty255", 32'(cnt[2]), 32'd255);
    chk("pwm_unset", 32'(cnt[3]), 32'd0);

    // Same-cycle write and read returns the old value.
    wr(4'd1, 32'h0F);
    acc(1'b1, 1'b1, 4'd1, 32'hF0, model_rd(4'd1));
    rd(4'd1);

    // Unmapped accesses, read-only STATUS, field truncation.
    rd(4'd12);
    acc(1'b1, 1'b0, 4'd12, 32'hFFFF_FFFF, 32'd0);
    wr(4'd3, 32'hFFFF);
    for (int a = 0; a < 4 + NCH; a++) if (a != 3) rd(4'(a));
    wr(4'd1, 32'hFFFF_FF5A);
    rd(4'd1);
    wr(4'd0, 32'hFF);
    rd(4'd0);
    wr(4'd2, 32'hABCD_1234);
    rd(4'd2);
    wr(4'd11, 32'h1FF);
    rd(4'd11);
    rd(4'd15);

    repeat (4) step();
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
